// File: rtl/penc_pkg.sv
// rtl/penc_pkg.sv - shared width and one-hot helpers for the priority encoder pipeline
package penc_pkg;

   localparam int PENC_MAX_N  = 64;
   localparam int PENC_MAX_IW = 6;

   // Index width for an N-line encoder, never narrower than one bit
   function automatic int penc_iw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One-hot vector with only bit idx set; callers truncate to their own width
   function automatic logic [PENC_MAX_N-1:0] penc_onehot(input logic [PENC_MAX_IW-1:0] idx);
      logic [PENC_MAX_N-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/penc_pick.sv
// rtl/penc_pick.sv - combinational highest-index picker with an optional preference mask
module penc_pick
   import penc_pkg::*;
#(
   parameter int  N  = 8,
   localparam int IW = penc_iw(N)
) (
   input  logic [N-1:0]  vec,
   input  logic [N-1:0]  mask,
   output logic          any,
   output logic [IW-1:0] idx
);

   logic [N-1:0]  masked;
   logic          masked_any;
   logic [IW-1:0] masked_idx;
   logic [IW-1:0] full_idx;

   assign masked     = vec & mask;
   assign masked_any = |masked;
   assign any        = |vec;

   // Highest set index of the full vector and of the masked subset (later hits overwrite)
   always_comb begin
      full_idx   = '0;
      masked_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            full_idx = IW'(i);
         end
         if (masked[i]) begin
            masked_idx = IW'(i);
         end
      end
   end

   // Preferred (masked) candidates win; otherwise fall back to the whole vector
   assign idx = masked_any ? masked_idx : full_idx;

endmodule

// File: rtl/priority_encoder_pipe.sv
// rtl/priority_encoder_pipe.sv - registered priority encoder with pending register; PENC_ROUND_ROBIN_EN selects round-robin
module priority_encoder_pipe
   import penc_pkg::*;
#(
   parameter int  N  = 8,
   localparam int IW = penc_iw(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_i,
   input  logic          ack_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o,
   output logic [N-1:0]  pending_o
);

   logic [N-1:0]  pend_q;
   logic [N-1:0]  pick_mask;
   logic [N-1:0]  loaded_onehot;
   logic          load;
   logic          pick_any;
   logic [IW-1:0] pick_idx;

   // The output stage may take a new winner when empty or when the consumer accepts
   assign load = !valid_o || ack_i;

`ifdef PENC_ROUND_ROBIN_EN
   logic [IW-1:0] last_q;

   // Prefer indices strictly below the previous winner so every line gets its turn
   always_comb begin
      pick_mask = '0;
      for (int i = 0; i < N; i++) begin
         pick_mask[i] = (IW'(i) < last_q);
      end
   end

   // Remember each winner that is loaded into the output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
      end else if (load && pick_any) begin
         last_q <= pick_idx;
      end
   end
`else
   assign pick_mask = '0;
`endif

   penc_pick #(
      .N (N)
   ) u_pick (
      .vec  (pend_q),
      .mask (pick_mask),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign loaded_onehot = (load && pick_any) ? N'(penc_onehot(PENC_MAX_IW'(pick_idx))) : '0;

   // Drop the bit being granted, then merge new requests so a re-request on it stays pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~loaded_onehot) | req_i;
      end
   end

   // Output stage: reload on load, otherwise hold the presented index stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_o <= 1'b0;
         idx_o   <= '0;
      end else if (load) begin
         if (pick_any) begin
            valid_o <= 1'b1;
            idx_o   <= pick_idx;
         end else begin
            valid_o <= 1'b0;
         end
      end
   end

   assign pending_o = pend_q;

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// tb/tb_priority_encoder_pipe.sv - randomized bench with behavioural model for priority_encoder_pipe
module tb_priority_encoder_pipe;

`ifdef PENC_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] req8;
   logic       ack8;
   logic       valid8;
   logic [2:0] idx8;
   logic [7:0] pend8;
   logic [3:0] req4;
   logic       ack4;
   logic       valid4;
   logic [1:0] idx4;
   logic [3:0] pend4;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   priority_encoder_pipe #(.N(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req8),
      .ack_i     (ack8),
      .valid_o   (valid8),
      .idx_o     (idx8),
      .pending_o (pend8)
   );

   priority_encoder_pipe #(.N(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req4),
      .ack_i     (ack4),
      .valid_o   (valid4),
      .idx_o     (idx4),
      .pending_o (pend4)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner rule: below the last winner first (round-robin only), else the highest set line
   function automatic int winner(input logic [63:0] v, input int n, input int last);
      int top;
      top = RR_EN ? last : 0;
      for (int i = top - 1; i >= 0; i--) begin
         if (v[i]) return i;
      end
      for (int i = n - 1; i >= 0; i--) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   // Behavioural model: index 0 tracks the N=8 instance, index 1 the N=4 instance
   logic [63:0] m_p     [2];
   logic        m_valid [2];
   int          m_idx   [2];
   int          m_last  [2];
   logic [63:0] req_v   [2];
   logic        ack_v   [2];

   always_comb begin
      req_v[0] = {56'b0, req8};
      req_v[1] = {60'b0, req4};
      ack_v[0] = ack8;
      ack_v[1] = ack4;
   end

   always @(posedge clk or negedge rst_n) begin : model
      logic [63:0] p;
      int          w;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            m_p[k]     <= '0;
            m_valid[k] <= 1'b0;
            m_idx[k]   <= 0;
            m_last[k]  <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            p = m_p[k];
            if (!m_valid[k] || ack_v[k]) begin
               w = winner(p, (k == 0) ? 8 : 4, m_last[k]);
               if (w >= 0) begin
                  m_valid[k] <= 1'b1;
                  m_idx[k]   <= w;
                  m_last[k]  <= w;
                  p[w]       = 1'b0;
               end else begin
                  m_valid[k] <= 1'b0;
               end
            end
            m_p[k] <= p | req_v[k];
         end
      end
   end

   // Every cycle out of reset, both instances must match the model
   always @(negedge clk) begin
      if (rst_n) begin
         check("valid8", {63'b0, valid8}, {63'b0, m_valid[0]});
         check("idx8",   {61'b0, idx8},   64'(m_idx[0]));
         check("pend8",  {56'b0, pend8},  m_p[0]);
         check("valid4", {63'b0, valid4}, {63'b0, m_valid[1]});
         check("idx4",   {62'b0, idx4},   64'(m_idx[1]));
         check("pend4",  {60'b0, pend4},  m_p[1]);
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req8  = '0;
      ack8  = 1'b0;
      req4  = '0;
      ack4  = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   int exp_seq [9];

   initial begin
      rst_n = 1'b0;
      req8  = '0;
      ack8  = 1'b0;
      req4  = '0;
      ack4  = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp_seq[i] = RR_EN ? ((i < 8) ? 7 - i : 7) : 7;
      end

      do_reset();
      cyc();
      check("reset_valid", {63'b0, valid8}, 64'd0);
      check("reset_idx",   {61'b0, idx8},   64'd0);
      check("reset_pend",  {56'b0, pend8},  64'd0);

      // Two requests drained with ack held high
      do_reset();
      ack8 = 1'b1;
      req8 = 8'h90;
      cyc();
      req8 = 8'h00;
      check("t90_pend_latched", {56'b0, pend8}, 64'h90);
      check("t90_not_yet",      {63'b0, valid8}, 64'd0);
      cyc();
      check("t90_first_valid",  {63'b0, valid8}, 64'd1);
      check("t90_first_idx",    {61'b0, idx8},   64'd7);
      check("t90_first_pend",   {56'b0, pend8},  64'h10);
      cyc();
      check("t90_second_idx",   {61'b0, idx8},   64'd4);
      check("t90_second_valid", {63'b0, valid8}, 64'd1);
      cyc();
      check("t90_empty",        {63'b0, valid8}, 64'd0);

      // Held grant without ack, then two single acks
      do_reset();
      req8 = 8'h05;
      cyc();
      req8 = 8'h00;
      cyc();
      for (int i = 0; i < 4; i++) begin
         check("t05_hold_idx",  {61'b0, idx8},  64'd2);
         check("t05_hold_pend", {56'b0, pend8}, 64'h01);
         cyc();
      end
      ack8 = 1'b1;
      cyc();
      ack8 = 1'b0;
      check("t05_next_idx",   {61'b0, idx8},   64'd0);
      check("t05_next_valid", {63'b0, valid8}, 64'd1);
      check("t05_next_pend",  {56'b0, pend8},  64'h00);
      cyc(2);
      check("t05_still_held", {61'b0, idx8},   64'd0);
      ack8 = 1'b1;
      cyc();
      ack8 = 1'b0;
      check("t05_empty",      {63'b0, valid8}, 64'd0);

      // Re-request of the line currently presented
      do_reset();
      req8 = 8'h20;
      cyc();
      req8 = 8'h00;
      cyc();
      check("t20_idx", {61'b0, idx8}, 64'd5);
      req8 = 8'h20;
      cyc();
      req8 = 8'h00;
      check("t20_pend_set", {56'b0, pend8}, 64'h20);
      check("t20_held",     {61'b0, idx8},  64'd5);
      ack8 = 1'b1;
      cyc();
      ack8 = 1'b0;
      check("t20_regrant_valid", {63'b0, valid8}, 64'd1);
      check("t20_regrant_idx",   {61'b0, idx8},   64'd5);
      check("t20_regrant_pend",  {56'b0, pend8},  64'h00);

      // All lines requesting continuously
      do_reset();
      ack8 = 1'b1;
      req8 = 8'hFF;
      cyc(2);
      for (int i = 0; i < 9; i++) begin
         check("tff_seq", {61'b0, idx8}, 64'(exp_seq[i]));
         cyc();
      end
      req8 = 8'h00;
      cyc(10);
      check("tff_drained", {63'b0, valid8}, 64'd0);

      // Asynchronous reset between edges while holding a grant
      do_reset();
      req8 = 8'h3C;
      cyc(2);
      req8 = 8'h00;
      check("t3c_valid", {63'b0, valid8}, 64'd1);
      check("t3c_idx",   {61'b0, idx8},   64'd5);
      check("t3c_pend",  {56'b0, pend8},  64'h3C);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", {63'b0, valid8}, 64'd0);
      check("async_idx",   {61'b0, idx8},   64'd0);
      check("async_pend",  {56'b0, pend8},  64'd0);
      cyc();
      rst_n = 1'b1;

      // Narrow instance: isolated requests with ack held
      do_reset();
      ack4 = 1'b1;
      req4 = 4'b1001;
      cyc();
      req4 = 4'b0000;
      cyc();
      check("n4_1001", {62'b0, idx4}, 64'd3);
      cyc(3);
      req4 = 4'b0101;
      cyc();
      req4 = 4'b0000;
      cyc();
      check("n4_0101", {62'b0, idx4}, 64'd2);
      cyc(3);
      req4 = 4'b0001;
      cyc();
      req4 = 4'b0000;
      cyc();
      check("n4_0001", {62'b0, idx4}, 64'd0);
      cyc(3);

      // Random traffic on both instances, checked against the model every cycle
      for (int i = 0; i < 800; i++) begin
         req8 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         ack8 = 1'($urandom_range(0, 1));
         req4 = 4'($urandom_range(0, 15));
         ack4 = 1'b1;
         cyc();
      end
      req8 = '0;
      req4 = '0;
      ack8 = 1'b1;
      cyc(12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/priority_encoder_pipe.md
PRIORITY_ENCODER_PIPE -- requirements
Module: priority_encoder_pipe

Interface
REQ-001 SHALL have parameter N, default 8, number of request lines (legal range 2..64).
REQ-002 SHALL have derived localparam IW = max(1, clog2(N)), the index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_i  input  N  request pulses; each set bit is ORed into the pending register.
REQ-006 SHALL have port ack_i  input  1  consumer accepts the presented index this cycle.
REQ-007 SHALL have port valid_o  output  1  idx_o holds a granted request.
REQ-008 SHALL have port idx_o  output  IW  binary index of the granted request.
REQ-009 SHALL have port pending_o  output  N  pending register, not yet granted.

Function
REQ-010 SHALL keep an N-bit pending register P and an output stage (valid_o, idx_o), all flops; no combinational path from req_i to any output.
REQ-011 SHALL define load = !valid_o || ack_i, and cand = P.
REQ-012 SHALL, on load with cand != 0: valid_o <= 1; idx_o <= winner(cand); winner bit removed from P at the same edge.
REQ-013 SHALL, on load with cand == 0: valid_o <= 0; idx_o holds its value.
REQ-014 SHALL hold valid_o and idx_o stable while valid_o && !ack_i.
REQ-015 SHALL update P <= (P & ~loaded_onehot) | req_i each cycle; a new request on the bit being granted that edge stays pending.
REQ-016 SHALL latch a request into P at the edge after it is applied and present it on valid_o/idx_o no earlier than the following edge: minimum latency 2 cycles.
REQ-017 SHALL give fixed priority by default: highest set index wins (N=4, 1001 -> 3).
REQ-018 SHALL treat ack_i while valid_o == 0 as a no-op.
REQ-019 SHALL have two implicit states, EMPTY (valid_o=0) and HOLD (valid_o=1):
- EMPTY -> HOLD when P != 0.
- HOLD -> EMPTY on ack_i with P == 0.
- HOLD -> HOLD on ack_i with P != 0 (back-to-back grant, no bubble), or while !ack_i.

Reset
REQ-020 SHALL, while rst_n = 0, immediately set valid_o = 0, idx_o = 0, P = 0 and the round-robin pointer = 0, including mid-transfer.
REQ-021 SHALL accept requests from the first rising edge after rst_n deasserts.

Configuration
REQ-022 SHALL support macro PENC_ROUND_ROBIN_EN:
- Defined: a pointer register last (IW bits, reset 0) records each loaded winner. winner = highest set index strictly below last; if none, highest set index overall.
- Undefined: fixed priority per REQ-017; no pointer flop exists.
- Both builds SHALL have identical ports.

Structure
REQ-023 SHALL place the IW computation function and a onehot-from-index helper in shared package penc_pkg.
REQ-024 SHALL implement winner selection in combinational sub-module penc_pick (parameter N; inputs vector and optional mask; outputs any and idx), instantiated once.

Verification
REQ-025 SHALL cover: N=8, ack_i=1, req_i=8'h90 for one cycle -> valid_o=1 with idx_o=7 two edges later, then idx_o=4, then valid_o=0.
REQ-026 SHALL cover: N=8, ack_i=0, req_i=8'h05 for one cycle -> idx_o=2 held indefinitely, pending_o=8'h01; one-cycle ack_i -> idx_o=0 next edge; second ack_i -> valid_o=0.
REQ-027 SHALL cover: while idx_o=5 is held, req_i=8'h20 -> pending_o bit 5 set; after ack_i, idx_o=5 is re-granted.
REQ-028 SHALL cover: req_i=8'hFF held, ack_i=1 -> fixed build gives idx_o 7,7,7...; PENC_ROUND_ROBIN_EN build gives 7,6,5,4,3,2,1,0,7.
REQ-029 SHALL cover: rst_n pulled low asynchronously between edges while valid_o=1 and pending_o=8'h3C -> all outputs 0 without a clock edge.
REQ-030 SHALL cover: N=4, random req_i with ack_i=1 -> idx_o equals highest set bit of each sampled request (4'b1001 -> 3, 4'b0101 -> 2, 4'b0001 -> 0), checked against a scoreboard.
